// File: rtl/mcmc_histogram.sv
// Result-side consumer of the MCMC sampler: captures a batch of LANES sampled states, serialises
// them one lane per cycle into a saturating per-state histogram, and offers a registered readout port.
module mcmc_histogram #(
   parameter int LANES       = 32,
   parameter int RESULT_SIZE = 5,
   parameter int POSSI_S     = 32,
   parameter int CNT_WID     = 16,
   parameter int TOT_WID     = 32
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           enable,
   input  logic                           done,
   input  logic [RESULT_SIZE*LANES-1:0]   result,
   input  logic                           clear,
   input  logic                           rd_en,
   input  logic [RESULT_SIZE-1:0]         rd_addr,
   output logic [CNT_WID-1:0]             rd_data,
   output logic                           rd_valid,
   output logic                           busy,
   output logic [TOT_WID-1:0]             total,
   output logic                           drop,
   output logic                           sat
);

   localparam int IDX_WID = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(LANES - 1);
   localparam logic [IDX_WID-1:0] IDX_ONE  = {{(IDX_WID-1){1'b0}}, 1'b1};
   localparam logic [CNT_WID-1:0] CNT_MAX  = {CNT_WID{1'b1}};
   localparam logic [CNT_WID-1:0] CNT_ONE  = {{(CNT_WID-1){1'b0}}, 1'b1};
   localparam logic [TOT_WID-1:0] TOT_MAX  = {TOT_WID{1'b1}};
   localparam logic [TOT_WID-1:0] TOT_ONE  = {{(TOT_WID-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t                         state_r;
   state_t                         state_s;
   logic                           accept_s;
   logic                           step_s;
   logic                           last_s;
   logic [IDX_WID-1:0]             idx_r;
   logic [RESULT_SIZE*LANES-1:0]   shadow_r;
   logic [RESULT_SIZE-1:0]         lane_s;
   logic                           lane_ok_s;
   logic [CNT_WID-1:0]             bins_r [POSSI_S];
   logic [CNT_WID-1:0]             bin_cur_s;
   logic                           bin_full_s;
   logic                           bin_near_s;
   logic                           tot_full_s;
   logic                           tot_near_s;

   // Next-state decode; clear abandons any batch and blocks a same-cycle capture.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      step_s   = 1'b0;
      last_s   = 1'b0;
      if (clear) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (enable && done) begin
                  state_s  = ACCUM;
                  accept_s = 1'b1;
               end else begin
                  state_s = IDLE;
               end
            end
            ACCUM: begin
               step_s = 1'b1;
               if (idx_r == LAST_IDX) begin
                  last_s  = 1'b1;
                  state_s = IDLE;
               end else begin
                  state_s = ACCUM;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Current lane and saturation lookahead for the bin it targets.
   always_comb begin
      lane_s     = shadow_r[idx_r*RESULT_SIZE +: RESULT_SIZE];
      lane_ok_s  = (int'(lane_s) < POSSI_S);
      bin_cur_s  = {CNT_WID{1'b0}};
      if (lane_ok_s) begin
         bin_cur_s = bins_r[lane_s];
      end else begin
         bin_cur_s = {CNT_WID{1'b0}};
      end
      bin_full_s = lane_ok_s && (bin_cur_s == CNT_MAX);
      bin_near_s = lane_ok_s && (bin_cur_s >= (CNT_MAX - CNT_ONE));
      tot_full_s = (total == TOT_MAX);
      tot_near_s = (total >= (TOT_MAX - TOT_ONE));
   end

   // Histogram, counters, sticky flags and readout port.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < POSSI_S; i++) begin
            bins_r[i] <= {CNT_WID{1'b0}};
         end
         shadow_r <= {(RESULT_SIZE*LANES){1'b0}};
         idx_r    <= {IDX_WID{1'b0}};
         total    <= {TOT_WID{1'b0}};
         busy     <= 1'b0;
         drop     <= 1'b0;
         sat      <= 1'b0;
         rd_data  <= {CNT_WID{1'b0}};
         rd_valid <= 1'b0;
      end else begin
         // Readout sees bins as held before this edge, including on a clear edge.
         rd_valid <= rd_en;
         if (rd_en) begin
            if (int'(rd_addr) < POSSI_S) begin
               rd_data <= bins_r[rd_addr];
            end else begin
               rd_data <= {CNT_WID{1'b0}};
            end
         end else begin
            rd_data <= rd_data;
         end
         busy <= (state_s == ACCUM);
         if (clear) begin
            for (int i = 0; i < POSSI_S; i++) begin
               bins_r[i] <= {CNT_WID{1'b0}};
            end
            idx_r <= {IDX_WID{1'b0}};
            total <= {TOT_WID{1'b0}};
            drop  <= 1'b0;
            sat   <= 1'b0;
         end else begin
            if (accept_s) begin
               shadow_r <= result;
               idx_r    <= {IDX_WID{1'b0}};
            end
            if ((state_r == ACCUM) && enable && done) begin
               drop <= 1'b1;
            end
            if (step_s) begin
               idx_r <= last_s ? {IDX_WID{1'b0}} : (idx_r + IDX_ONE);
               if (lane_ok_s && !bin_full_s) begin
                  bins_r[lane_s] <= bin_cur_s + CNT_ONE;
               end
               if (!tot_full_s) begin
                  total <= total + TOT_ONE;
               end
               if (bin_near_s || tot_near_s) begin
                  sat <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mcmc_histogram.sv
// Randomised scoreboard bench for mcmc_histogram (8-bit bins so saturation is reachable).
module tb_mcmc_histogram;

   localparam int LANES = 32;
   localparam int RS    = 5;
   localparam int NB    = 32;
   localparam int CW    = 8;
   localparam int TW    = 32;
   localparam int RW    = RS * LANES;
   localparam longint CMAX = (64'd1 << CW) - 64'd1;
   localparam longint TMAX = (64'd1 << TW) - 64'd1;

   logic          clk = 1'b0;
   logic          rstn;
   logic          enable;
   logic          done;
   logic [RW-1:0] result;
   logic          clear;
   logic          rd_en;
   logic [RS-1:0] rd_addr;
   logic [CW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
   logic [TW-1:0] total;
   logic          drop;
   logic          sat;

   mcmc_histogram #(.LANES(LANES), .RESULT_SIZE(RS), .POSSI_S(NB), .CNT_WID(CW), .TOT_WID(TW)) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .done(done), .result(result), .clear(clear),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .total(total), .drop(drop), .sat(sat)
   );

   always #5 clk = ~clk;

   int     n_chk  = 0;
   int     n_fail = 0;
   int     rd_q[$];

   // reference model: whole batches are applied at the accept edge
   longint m_bins [NB];
   longint m_total;
   bit     m_drop;
   bit     m_sat;
   longint edge_n  = 0;
   longint free_at = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // readout monitor
   always @(negedge clk) begin
      if (rd_valid) begin
         n_chk++;
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: got rd_valid with data %0d expected no read", rd_data);
         end else begin
            int e;
            e = rd_q.pop_front();
            if (int'(rd_data) != e) begin
               n_fail++;
               $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
            end
         end
      end
   end

   function automatic void model_clear();
      for (int i = 0; i < NB; i++) m_bins[i] = 0;
      m_total = 0;
      m_drop  = 1'b0;
      m_sat   = 1'b0;
      free_at = 0;
   endfunction

   function automatic void model_apply(input logic [RW-1:0] res);
      for (int i = 0; i < LANES; i++) begin
         int v;
         v = int'(res[i*RS +: RS]);
         if (m_total < TMAX) m_total = m_total + 1;
         if (m_total == TMAX) m_sat = 1'b1;
         if (v < NB) begin
            if (m_bins[v] < CMAX) m_bins[v] = m_bins[v] + 1;
            if (m_bins[v] == CMAX) m_sat = 1'b1;
         end
      end
   endfunction

   function automatic logic [RW-1:0] pat_const(input int v);
      logic [RW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*RS +: RS] = RS'(v);
      return r;
   endfunction

   function automatic logic [RW-1:0] pat_ramp();
      logic [RW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*RS +: RS] = RS'(i % NB);
      return r;
   endfunction

   // one clock of stimulus; rexp >= 0 overrides the model's read expectation
   task automatic step(input logic d, input logic [RW-1:0] res, input logic cl,
                       input logic re, input logic [RS-1:0] ra, input int rexp);
      longint s;
      s       = edge_n + 1;
      done    = d;
      result  = res;
      clear   = cl;
      rd_en   = re;
      rd_addr = ra;
      if (re) begin
         if (rexp >= 0) rd_q.push_back(rexp);
         else if (int'(ra) < NB) rd_q.push_back(int'(m_bins[ra]));
         else rd_q.push_back(0);
      end
      if (cl) begin
         model_clear();
      end else if (d && enable) begin
         if (s >= free_at) begin
            model_apply(res);
            free_at = s + LANES + 1;
         end else begin
            m_drop = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      edge_n = s;
      done   = 1'b0;
      clear  = 1'b0;
      rd_en  = 1'b0;
      chk("busy", longint'(busy), (edge_n + 1 < free_at) ? 1 : 0);
      chk("drop", longint'(drop), longint'(m_drop));
      if (edge_n + 1 >= free_at) begin
         chk("total", longint'(total), m_total);
         chk("sat", longint'(sat), longint'(m_sat));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, -1);
   endtask

   task automatic batch(input logic [RW-1:0] res);
      step(1'b1, res, 1'b0, 1'b0, '0, -1);
      idle(LANES + 1);
   endtask

   task automatic read_all();
      for (int a = 0; a < NB; a++) step(1'b0, '0, 1'b0, 1'b1, RS'(a), -1);
      idle(2);
   endtask

   initial begin
      int busy_cnt;
      logic [RW-1:0] rr;
      rstn = 1'b0; enable = 1'b0; done = 1'b0; result = '0;
      clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
      model_clear();

      // T1 reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_total", longint'(total), 0);
      chk("rst_drop", longint'(drop), 0);
      chk("rst_sat", longint'(sat), 0);
      chk("rst_rd_valid", longint'(rd_valid), 0);
      rstn = 1'b1;
      enable = 1'b1;
      read_all();

      // T2 all lanes = 3, busy exactly LANES cycles
      step(1'b1, pat_const(3), 1'b0, 1'b0, '0, -1);
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < LANES + 4; i++) begin
         idle(1);
         if (busy === 1'b1) busy_cnt++;
      end
      chk("t2_busy_cycles", busy_cnt, LANES);
      chk("t2_total", longint'(total), 32);
      read_all();

      // T3 ramp twice
      step(1'b0, '0, 1'b1, 1'b0, '0, -1);
      batch(pat_ramp());
      read_all();
      batch(pat_ramp());
      chk("t3_total", longint'(total), 64);
      read_all();

      // T4 overlap 5 cycles later, then dropped/accepted at the busy boundary
      step(1'b0, '0, 1'b1, 1'b0, '0, -1);
      step(1'b1, pat_const(7), 1'b0, 1'b0, '0, -1);
      idle(4);
      step(1'b1, pat_const(9), 1'b0, 1'b0, '0, -1);
      chk("t4_drop", longint'(drop), 1);
      idle(LANES);
      chk("t4_total", longint'(total), 32);
      read_all();
      step(1'b0, '0, 1'b1, 1'b0, '0, -1);
      step(1'b1, pat_const(1), 1'b0, 1'b0, '0, -1);
      idle(LANES - 1);
      step(1'b1, pat_const(2), 1'b0, 1'b0, '0, -1);
      step(1'b1, pat_const(4), 1'b0, 1'b0, '0, -1);
      idle(LANES + 1);
      read_all();
      // done with enable low is ignored entirely
      step(1'b0, '0, 1'b1, 1'b0, '0, -1);
      enable = 1'b0;
      step(1'b1, pat_const(5), 1'b0, 1'b0, '0, -1);
      idle(3);
      enable = 1'b1;
      chk("t4_en0_total", longint'(total), 0);

      // T5 saturation of bin 0
      for (int b = 0; b < 7; b++) batch(pat_const(0));
      chk("t5_sat_before", longint'(sat), 0);
      batch(pat_const(0));
      chk("t5_sat", longint'(sat), 1);
      chk("t5_total", longint'(total), 256);
      step(1'b0, '0, 1'b0, 1'b1, '0, 255);
      batch(pat_const(0));
      chk("t5_total_more", longint'(total), 288);
      read_all();

      // T6 read on clear edge sees pre-clear value; read during increment; clear at lane 10
      step(1'b0, '0, 1'b1, 1'b1, '0, 255);
      step(1'b1, pat_const(0), 1'b0, 1'b0, '0, -1);
      idle(5);
      step(1'b0, '0, 1'b0, 1'b1, '0, 5);
      idle(4);
      step(1'b0, '0, 1'b1, 1'b0, '0, -1);
      chk("t6_busy", longint'(busy), 0);
      chk("t6_total", longint'(total), 0);
      read_all();

      // randomised traffic
      for (int c = 0; c < 1500; c++) begin
         logic d, cl, re;
         for (int k = 0; k < RW / 32; k++) rr[k*32 +: 32] = $urandom;
         enable = ($urandom_range(0, 9) != 0);
         d  = ($urandom_range(0, 11) == 0);
         cl = ($urandom_range(0, 299) == 0);
         re = (edge_n + 1 >= free_at) && ($urandom_range(0, 2) == 0);
         step(d, rr, cl, re, RS'($urandom_range(0, NB - 1)), -1);
      end
      enable = 1'b1;
      idle(LANES + 2);
      read_all();

      chk("rd_queue_drained", rd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
